serial_bridge: RTL



---
 rtl/serial_bridge.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_bridge.sv
// Byte-serial bridge: 8N1 UART RX/TX with FWFT receive FIFO and transmit FIFO.
// Optional internal loopback of uart_tx into the receiver with SERIAL_LOOPBACK_EN.
module serial_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] cpu_rx_data,
  output logic       cpu_rx_valid,
  input  logic       cpu_rx_rden,
  input  logic [7:0] cpu_tx_data,
  input  logic       cpu_tx_wren,
  output logic       cpu_tx_ready,
  input  logic       loopback,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic rx_src;
`ifdef SERIAL_LOOPBACK_EN
  assign rx_src = loopback ? uart_tx : uart_rx;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_src = uart_rx;
`endif

  logic rx_meta, rx_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
    end
  end

  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push;

  // Start bit is re-checked at its midpoint; later samples land mid-bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_push      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_push      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_sync) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_sync) rx_push      <= 1'b1;
            else         rx_frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  logic [7:0]     rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wp, rx_rp;
  logic rx_empty, rx_full, rx_pop, rx_wr;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp == {~rx_rp[FIFO_AW], rx_rp[FIFO_AW-1:0]});
  assign rx_pop   = cpu_rx_rden && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clock) begin
    if (rx_wr) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_wr) rx_overrun <= 1'b1;
    end
  end

  assign cpu_rx_valid = !rx_empty;
  assign cpu_rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];

  logic [7:0]       tx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  assign tx_empty     = (tx_wp == tx_rp);
  assign tx_full      = (tx_wp == {~tx_rp[FIFO_AW], tx_rp[FIFO_AW-1:0]});
  assign tx_push      = cpu_tx_wren && !tx_full;
  assign cpu_tx_ready = !tx_full;
  // Popping at the end of STOP chains frames without an idle gap.
  assign tx_pop = !tx_empty && ((tx_state == S_IDLE) ||
                  ((tx_state == S_STOP) && (tx_cnt == CW'(CLKS_PER_BIT - 1))));

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= cpu_tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
            tx_state <= S_START;
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
              tx_state <= S_START;
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
